// File: rtl/xyz_operand_mux.sv
// ---------------------------------------------------------------------------
// xyz_operand_mux
//
// Purpose:
//   Builds the X, Y and Z operands that feed the ALU adder of a DSP48E1-style
//   slice. All three come from one 7-bit OPMODE word. The block offers:
//     - an optional OPMODE register,
//     - an optional output pipeline stage with a clock enable,
//     - valid tracking,
//     - illegal-OPMODE detection with a sticky error flag.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   ce_opmode  OPMODE register enable (no effect when OPMODEREG=0)
//   ce_out     output stage enable (no effect when OUTREG=0)
//   opmode     [1:0] X select, [3:2] Y select, [6:4] Z select
//   in_valid   source operands are valid this cycle
//   ab         concatenated A:B operand
//   m          signed multiplier product, M_WIDTH bits
//   c          C operand
//   p          P feedback
//   pcin       cascade input
//   clr_err    clears err_sticky
//   x_out      X operand
//   y_out      Y operand
//   z_out      Z operand
//   out_valid  X/Y/Z outputs are valid
//   opmode_err the current outputs came from an illegal OPMODE
//   err_sticky latched illegal-OPMODE indication
// ---------------------------------------------------------------------------
module xyz_operand_mux #(
    parameter int WIDTH     = 48,
    parameter int M_WIDTH   = 43,
    parameter int SHIFT     = 17,
    parameter int OPMODEREG = 1,
    parameter int OUTREG    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce_opmode,
    input  logic               ce_out,
    input  logic [6:0]         opmode,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   ab,
    input  logic [M_WIDTH-1:0] m,
    input  logic [WIDTH-1:0]   c,
    input  logic [WIDTH-1:0]   p,
    input  logic [WIDTH-1:0]   pcin,
    input  logic               clr_err,
    output logic [WIDTH-1:0]   x_out,
    output logic [WIDTH-1:0]   y_out,
    output logic [WIDTH-1:0]   z_out,
    output logic               out_valid,
    output logic               opmode_err,
    output logic               err_sticky
);

    logic [6:0]       opmode_q;
    logic [6:0]       eop;
    logic [1:0]       xSel;
    logic [1:0]       ySel;
    logic [2:0]       zSel;
    logic [WIDTH-1:0] mExt;
    logic [WIDTH-1:0] pcinShift;
    logic [WIDTH-1:0] pShift;
    logic             xIsM;
    logic             yIsM;

    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] z_d;
    logic             err_d;

    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] z_q;
    logic             valid_q;
    logic             err_q;
    logic             err_sticky_q;

    // The OPMODE register always exists. When OPMODEREG=0 it is simply not
    // selected, so the raw opmode drives selection with no latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opmode_q <= '0;
        end else if (ce_opmode) begin
            opmode_q <= opmode;
        end
    end

    assign eop  = (OPMODEREG != 0) ? opmode_q : opmode;
    assign xSel = eop[1:0];
    assign ySel = eop[3:2];
    assign zSel = eop[6:4];

    assign mExt      = {{(WIDTH-M_WIDTH){m[M_WIDTH-1]}}, m};
    assign pcinShift = WIDTH'($signed(pcin) >>> SHIFT);
    assign pShift    = WIDTH'($signed(p) >>> SHIFT);

    // The multiplier product is split across X and Y. It therefore only makes
    // sense when both X and Y select it; a lone M select is illegal and
    // drives zero.
    assign xIsM = (xSel == 2'b01);
    assign yIsM = (ySel == 2'b01);

    always_comb begin
        x_d = '0;
        unique case (xSel)
            2'b00: x_d = '0;
            2'b01: x_d = (xIsM && yIsM) ? mExt : '0;
            2'b10: x_d = p;
            2'b11: x_d = ab;
        endcase
    end

    always_comb begin
        y_d = '0;
        unique case (ySel)
            2'b00: y_d = '0;
            2'b01: y_d = (xIsM && yIsM) ? mExt : '0;
            2'b10: y_d = '1;
            2'b11: y_d = c;
        endcase
    end

    always_comb begin
        z_d = '0;
        unique case (zSel)
            3'b000: z_d = '0;
            3'b001: z_d = pcin;
            3'b010: z_d = p;
            3'b011: z_d = c;
            3'b100: z_d = p;
            3'b101: z_d = pcinShift;
            3'b110: z_d = pShift;
            3'b111: z_d = '0;
        endcase
    end

    assign err_d = (xIsM ^ yIsM) | (zSel == 3'b111);

    // Output stage: data, valid and error flag advance together, so the error
    // flag always describes the operands it travels with.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (ce_out) begin
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            valid_q <= in_valid;
            err_q   <= err_d;
        end
    end

    assign x_out      = (OUTREG != 0) ? x_q     : x_d;
    assign y_out      = (OUTREG != 0) ? y_q     : y_d;
    assign z_out      = (OUTREG != 0) ? z_q     : z_d;
    assign out_valid  = (OUTREG != 0) ? valid_q : in_valid;
    assign opmode_err = (OUTREG != 0) ? err_q   : err_d;

    // Set has priority over clear so an error arriving on the same edge as
    // clr_err is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky_q <= 1'b0;
        end else if (out_valid && opmode_err) begin
            err_sticky_q <= 1'b1;
        end else if (clr_err) begin
            err_sticky_q <= 1'b0;
        end
    end

    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_xyz_operand_mux.sv
// Bench for xyz_operand_mux. Instance dutR uses the default registered
// configuration (OPMODEREG=1, OUTREG=1); instance dutC uses OPMODEREG=0,
// OUTREG=0. Both share the same stimulus.
module tb_xyz_operand_mux;

    localparam int W  = 48;
    localparam int MW = 43;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce_opmode;
    logic          ce_out;
    logic [6:0]    opmode;
    logic          in_valid;
    logic [W-1:0]  ab;
    logic [MW-1:0] m;
    logic [W-1:0]  c;
    logic [W-1:0]  p;
    logic [W-1:0]  pcin;
    logic          clr_err;

    logic [W-1:0]  xR, yR, zR;
    logic          vR, eR, sR;
    logic [W-1:0]  xC, yC, zC;
    logic          vC, eC, sC;

    always #5 clk = ~clk;

    xyz_operand_mux dutR (
        .clk(clk), .rst(rst), .ce_opmode(ce_opmode), .ce_out(ce_out),
        .opmode(opmode), .in_valid(in_valid), .ab(ab), .m(m), .c(c), .p(p),
        .pcin(pcin), .clr_err(clr_err),
        .x_out(xR), .y_out(yR), .z_out(zR),
        .out_valid(vR), .opmode_err(eR), .err_sticky(sR)
    );

    xyz_operand_mux #(.OPMODEREG(0), .OUTREG(0)) dutC (
        .clk(clk), .rst(rst), .ce_opmode(ce_opmode), .ce_out(ce_out),
        .opmode(opmode), .in_valid(in_valid), .ab(ab), .m(m), .c(c), .p(p),
        .pcin(pcin), .clr_err(clr_err),
        .x_out(xC), .y_out(yC), .z_out(zC),
        .out_valid(vC), .opmode_err(eC), .err_sticky(sC)
    );

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] z;
        logic         v;
        logic         e;
    } exp_t;

    int         total = 0;
    int         bad   = 0;
    exp_t       sbQ[$];
    exp_t       curExp;
    logic       expSticky;
    logic       expStickyC;
    logic [6:0] mdlOpq;

    // Reference selection behaviour for a given OPMODE on the current inputs
    function automatic exp_t model(input logic [6:0] op, input logic iv);
        exp_t                r;
        logic [W-1:0]        me;
        logic signed [W-1:0] sp;
        logic signed [W-1:0] spc;
        logic                xm;
        logic                ym;
        r   = '0;
        me  = {{(W-MW){m[MW-1]}}, m};
        sp  = $signed(p);
        spc = $signed(pcin);
        xm  = (op[1:0] == 2'b01);
        ym  = (op[3:2] == 2'b01);
        r.v = iv;
        case (op[1:0])
            2'b01:   r.x = (xm && ym) ? me : '0;
            2'b10:   r.x = p;
            2'b11:   r.x = ab;
            default: r.x = '0;
        endcase
        case (op[3:2])
            2'b01:   r.y = (xm && ym) ? me : '0;
            2'b10:   r.y = {W{1'b1}};
            2'b11:   r.y = c;
            default: r.y = '0;
        endcase
        case (op[6:4])
            3'd1:    r.z = pcin;
            3'd2:    r.z = p;
            3'd3:    r.z = c;
            3'd4:    r.z = p;
            3'd5:    r.z = spc >>> 17;
            3'd6:    r.z = sp >>> 17;
            default: r.z = '0;
        endcase
        r.e = (xm != ym) || (op[6:4] == 3'b111);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic iv, input logic ceo,
                                 input logic ceop, input logic clr);
        opmode    = op;
        in_valid  = iv;
        ce_out    = ceo;
        ce_opmode = ceop;
        clr_err   = clr;
    endtask

    task automatic randomData();
        ab   = {16'($urandom()), 32'($urandom())};
        m    = {11'($urandom()), 32'($urandom())};
        c    = {16'($urandom()), 32'($urandom())};
        p    = {16'($urandom()), 32'($urandom())};
        pcin = {16'($urandom()), 32'($urandom())};
    endtask

    // One clock: check the combinational instance, push the registered
    // instance's expected result, clock, then pop and compare.
    task automatic step();
        exp_t       cExp;
        exp_t       nExp;
        exp_t       got;
        logic       stNext;
        logic       stNextC;
        logic [6:0] opNow;
        logic       ceopNow;
        #1;
        cExp = model(opmode, in_valid);
        checkOutput("comb_x", xC, cExp.x);
        checkOutput("comb_y", yC, cExp.y);
        checkOutput("comb_z", zC, cExp.z);
        checkOutput("comb_valid", W'(vC), W'(cExp.v));
        checkOutput("comb_err", W'(eC), W'(cExp.e));
        nExp    = ce_out ? model(mdlOpq, in_valid) : curExp;
        sbQ.push_back(nExp);
        stNext  = (curExp.v & curExp.e) | (expSticky & ~clr_err);
        stNextC = (cExp.v & cExp.e) | (expStickyC & ~clr_err);
        opNow   = opmode;
        ceopNow = ce_opmode;
        @(posedge clk);
        #1;
        if (ceopNow) mdlOpq = opNow;
        expSticky  = stNext;
        expStickyC = stNextC;
        if (sbQ.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            got    = sbQ.pop_front();
            curExp = got;
            checkOutput("reg_x", xR, got.x);
            checkOutput("reg_y", yR, got.y);
            checkOutput("reg_z", zR, got.z);
            checkOutput("reg_valid", W'(vR), W'(got.v));
            checkOutput("reg_err", W'(eR), W'(got.e));
        end
        checkOutput("reg_sticky", W'(sR), W'(expSticky));
        checkOutput("comb_sticky", W'(sC), W'(expStickyC));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_x"}, xR, '0);
        checkOutput({tag, "_y"}, yR, '0);
        checkOutput({tag, "_z"}, zR, '0);
        checkOutput({tag, "_valid"}, W'(vR), '0);
        checkOutput({tag, "_err"}, W'(eR), '0);
        checkOutput({tag, "_sticky"}, W'(sR), '0);
        checkOutput({tag, "_sticky_comb"}, W'(sC), '0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(7'b0000000, 1'b0, 1'b1, 1'b1, 1'b0);
        ab = '0; m = '0; c = '0; p = '0; pcin = '0;
        curExp = '0; expSticky = 1'b0; expStickyC = 1'b0; mdlOpq = '0;
        #2;
        checkResetState("reset");
        @(negedge clk);
        rst = 1'b0;

        // All-zero OPMODE, valid data
        applyStimulus(7'b0000000, 1'b1, 1'b1, 1'b1, 1'b0);
        randomData();
        step();

        // Negative product through X and Y (two edges of latency)
        applyStimulus(7'b0000101, 1'b1, 1'b1, 1'b1, 1'b0);
        m = 43'h400_0000_0000;
        step();
        step();

        // Lone X=M: illegal, sticky sets and survives a legal OPMODE
        applyStimulus(7'b0000001, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        step();
        applyStimulus(7'b0000000, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        step();
        step();
        // Clear with no new error
        applyStimulus(7'b0000000, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        applyStimulus(7'b1110000, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        step();
        // Clear coincident with a new error: set wins
        applyStimulus(7'b1110000, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        applyStimulus(7'b0000000, 1'b1, 1'b1, 1'b1, 1'b0);
        step();

        // X=A:B, Y=all ones, Z=p>>>17
        applyStimulus(7'b1101011, 1'b1, 1'b1, 1'b1, 1'b0);
        ab = 48'h1234_5678_9ABC;
        p  = 48'h8000_0000_0000;
        step();
        step();
        checkOutput("direct_x", xR, 48'h1234_5678_9ABC);
        checkOutput("direct_y", yR, 48'hFFFF_FFFF_FFFF);
        checkOutput("direct_z", zR, 48'hFFFF_C000_0000);

        // Output stage held for three cycles while inputs move
        for (int i = 0; i < 3; i++) begin
            applyStimulus(7'(i * 37 + 3), i[0], 1'b0, 1'b1, 1'b0);
            randomData();
            step();
        end

        // OPMODE register held: new opmode ignored until re-enabled
        applyStimulus(7'b0111110, 1'b1, 1'b1, 1'b0, 1'b0);
        randomData();
        step();
        step();
        applyStimulus(7'b0111110, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        step();

        // Every Z select plus a mix of X/Y selects, random operands
        for (int i = 0; i < 16; i++) begin
            applyStimulus({3'(i % 8), 2'(i / 4), 2'(i)}, 1'b1, 1'b1, 1'b1, i[3]);
            randomData();
            step();
        end

        // Mid-stream reset with non-zero outputs and sticky set
        applyStimulus(7'b1111011, 1'b1, 1'b1, 1'b1, 1'b0);
        ab = 48'hDEAD_BEEF_0001;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        checkResetState("midreset");
        mdlOpq = '0; curExp = '0; expSticky = 1'b0; expStickyC = 1'b0;
        sbQ.delete();
        @(negedge clk);
        rst = 1'b0;

        // Normal operation right after release
        applyStimulus(7'b0110011, 1'b1, 1'b1, 1'b1, 1'b0);
        randomData();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        bad++;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] timeout");
    end

endmodule
